// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory fetch bus (req/addr out, ack/rdata back).
interface pc_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   modport master (output req, addr, input ack, rdata);
   modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register and IDLE/FETCH/EXEC fetch sequencer forming sequential, branch or jump next PC.
module pc_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [31:0]           branch_offset,
   input  logic                  branch_taken,
   input  logic                  jump,
   input  logic [25:0]           jump_index,
   input  logic                  stall,
   pc_fetch_unit_if.master       imem,
   output logic [31:0]           instr,
   output logic                  instr_valid,
   output logic [31:0]           pc,
   output logic [31:0]           pc_plus4
);
   typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
   state_t state, state_nxt;
   logic [31:0] next_pc;
   assign pc_plus4 = pc + 32'd4;
   assign next_pc = jump ? {pc_plus4[31:28], jump_index, 2'b00} :
                    branch_taken ? pc_plus4 + {branch_offset[31:2], 2'b00} : pc_plus4;
   assign imem.req = state == FETCH;
   assign imem.addr = pc;
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   state_nxt = imem.ack ? EXEC : FETCH;
         EXEC:    state_nxt = stall ? EXEC : FETCH;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
      end else begin
         state <= state_nxt;
         if (state == FETCH && imem.ack) begin
            instr       <= imem.rdata;
            instr_valid <= 1'b1;
         end
         if (state == EXEC && !stall) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, random retire sequence vs next-PC model, reset-during-fetch and PC wrap checks.
module tb_pc_fetch_unit;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [31:0] br_off = '0;
   logic br = 1'b0, jmp = 1'b0, stall = 1'b0;
   logic [25:0] jidx = '0;
   logic [31:0] instr, pc, pc_plus4;
   logic instr_valid;
   logic [31:0] instr2, pc2, pc4_2;
   logic valid2;
   logic z1 = 1'b0;
   logic [31:0] z32 = '0;
   logic [25:0] z26 = '0;
   int n_cmp = 0, n_fail = 0;
   logic [31:0] exp_pc;

   pc_fetch_unit_if bus ();
   pc_fetch_unit_if bus2 ();
   assign bus2.ack = bus2.req;
   assign bus2.rdata = 32'h2000_0001;

   always #5 clk = ~clk;

   pc_fetch_unit dut (
      .clk(clk), .reset(reset), .branch_offset(br_off), .branch_taken(br), .jump(jmp),
      .jump_index(jidx), .stall(stall), .imem(bus), .instr(instr), .instr_valid(instr_valid),
      .pc(pc), .pc_plus4(pc_plus4));

   pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset), .branch_offset(z32), .branch_taken(z1), .jump(z1),
      .jump_index(z26), .stall(z1), .imem(bus2), .instr(instr2), .instr_valid(valid2),
      .pc(pc2), .pc_plus4(pc4_2));

   typedef struct {
      logic [31:0] rdata;
      int          dly;
      logic [31:0] off;
      logic        b;
      logic        j;
      logic [25:0] ji;
      int          st;
      logic [31:0] exp_next;
   } vec_t;
   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] off,
                                            input logic b, input logic j, input logic [25:0] ji);
      logic [31:0] seq = p + 32'd4;
      if (j) return (seq & 32'hF000_0000) | (32'(ji) * 4);
      if (b) return seq + (off & 32'hFFFF_FFFC);
      return seq;
   endfunction

   task automatic run_instr(input string nm, input logic [31:0] rdata, input int dly,
                            input logic [31:0] off, input logic b, input logic j,
                            input logic [25:0] ji, input int st, input logic [31:0] exp_next);
      int t = 0;
      while (!bus.req && t < 8) begin
         @(negedge clk);
         t++;
      end
      chk({nm, "_req"}, 32'(bus.req), 32'd1);
      chk({nm, "_addr"}, bus.addr, exp_pc);
      repeat (dly) begin
         @(negedge clk);
         chk({nm, "_wait_req"}, 32'(bus.req), 32'd1);
         chk({nm, "_wait_addr"}, bus.addr, exp_pc);
      end
      bus.ack = 1'b1;
      bus.rdata = rdata;
      @(negedge clk);
      bus.ack = 1'b0;
      bus.rdata = 32'hBAD0_BAD0;
      chk({nm, "_instr"}, instr, rdata);
      chk({nm, "_valid"}, 32'(instr_valid), 32'd1);
      chk({nm, "_exec_req"}, 32'(bus.req), 32'd0);
      chk({nm, "_pc4"}, pc_plus4, exp_pc + 32'd4);
      br_off = off; br = b; jmp = j; jidx = ji; stall = st > 0;
      repeat (st) begin
         @(negedge clk);
         chk({nm, "_stall_instr"}, instr, rdata);
         chk({nm, "_stall_valid"}, 32'(instr_valid), 32'd1);
         chk({nm, "_stall_pc"}, pc, exp_pc);
      end
      stall = 1'b0;
      @(negedge clk);
      br = 1'b0; jmp = 1'b0;
      chk({nm, "_next_addr"}, bus.addr, exp_next);
      chk({nm, "_next_valid"}, 32'(instr_valid), 32'd0);
      chk({nm, "_next_req"}, 32'(bus.req), 32'd1);
      exp_pc = exp_next;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      bus.ack = 1'b0;
      bus.rdata = '0;
      exp_pc = 32'h0;
      tbl[0] = '{32'h2000_0001, 0, 32'h0,         0, 0, 26'h0,   0, 32'h0000_0004};
      tbl[1] = '{32'h2000_0001, 0, 32'h0,         0, 0, 26'h0,   0, 32'h0000_0008};
      tbl[2] = '{32'h0800_0004, 0, 32'h0,         0, 1, 26'h4,   0, 32'h0000_0010};
      tbl[3] = '{32'h1000_0008, 0, 32'h20,        1, 0, 26'h0,   0, 32'h0000_0034};
      tbl[4] = '{32'h0800_0004, 1, 32'h0,         0, 1, 26'h4,   0, 32'h0000_0010};
      tbl[5] = '{32'h1000_FFFC, 0, 32'hFFFF_FFF0, 1, 0, 26'h0,   0, 32'h0000_0004};
      tbl[6] = '{32'h1000_4000, 0, 32'h1000_003B, 1, 0, 26'h0,   0, 32'h1000_0040};
      tbl[7] = '{32'h0800_0100, 0, 32'h20,        1, 1, 26'h100, 0, 32'h1000_0400};
      tbl[8] = '{32'hABCD_1234, 0, 32'h0,         0, 0, 26'h0,   5, 32'h1000_0404};
      tbl[9] = '{32'h5555_AAAA, 2, 32'h40,        0, 0, 26'h0,   0, 32'h1000_0408};
      @(negedge clk);
      chk("rst_pc", pc, 32'h0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_req", 32'(bus.req), 32'd0);
      chk("rst_pc2", pc2, 32'hFFFF_FFFC);
      reset = 1'b0;
      chk("idle_req", 32'(bus.req), 32'd0);
      chk("idle_req2", 32'(bus2.req), 32'd0);
      @(negedge clk);
      chk("fetch0_req", 32'(bus.req), 32'd1);
      chk("fetch0_addr", bus.addr, 32'h0);
      chk("wrap_fetch_addr", bus2.addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_valid", 32'(valid2), 32'd1);
      chk("wrap_instr", instr2, 32'h2000_0001);
      chk("noack_hold_req", 32'(bus.req), 32'd1);
      @(negedge clk);
      chk("wrap_addr", bus2.addr, 32'h0);
      chk("wrap_pc", pc2, 32'h0);
      for (int i = 0; i < 10; i++)
         run_instr($sformatf("vec%0d", i), tbl[i].rdata, tbl[i].dly, tbl[i].off, tbl[i].b,
                   tbl[i].j, tbl[i].ji, tbl[i].st, tbl[i].exp_next);
      for (int i = 0; i < 40; i++) begin
         logic [31:0] rd, off;
         logic b, j;
         logic [25:0] ji;
         int dly, st;
         rd = $urandom; off = $urandom; ji = 26'($urandom);
         b = 1'($urandom); j = ($urandom_range(3) == 0);
         dly = $urandom_range(2); st = $urandom_range(2);
         run_instr($sformatf("rnd%0d", i), rd, dly, off, b, j, ji, st, ref_next(exp_pc, off, b, j, ji));
      end
      @(negedge clk);
      chk("late_wait1_req", 32'(bus.req), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("late_rst_req", 32'(bus.req), 32'd0);
      chk("late_rst_pc", pc, 32'h0);
      chk("late_rst_valid", 32'(instr_valid), 32'd0);
      bus.ack = 1'b1;
      bus.rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk("late_ack_rst_instr", instr, 32'h0);
      reset = 1'b0;
      chk("late_idle_req", 32'(bus.req), 32'd0);
      @(negedge clk);
      bus.ack = 1'b0;
      chk("late_ack_ignored_instr", instr, 32'h0);
      chk("late_ack_ignored_valid", 32'(instr_valid), 32'd0);
      chk("late_refetch_req", 32'(bus.req), 32'd1);
      chk("late_refetch_addr", bus.addr, 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
